// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// uart_mem_loader : 8N1 UART byte stream -> 32-bit word writes into a memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
// Rev 1.0
// ============================================================================

module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEM_WORDS    = 2056,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } load_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam load_state_t S_AFTER_DATA = S_CSUM;
`else
  localparam load_state_t S_AFTER_DATA = S_DONE;
`endif

  logic [1:0]       sync_q;
  logic             prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             w_rx, w_start_ok, w_byte_done, w_frame_err;

  load_state_t       state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [23:0]       word_q, word_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       n_q, n_d;
  logic              busy_q, busy_d;
  logic [15:0]       w_n;
  logic [16:0]       w_next_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign w_rx       = sync_q[1];
  assign w_n        = {shift_q, cnt_lo_q};
  assign w_next_idx = 17'(mem_addr_q) + 17'd1;

  // Receiver: start bit re-checked at half a bit, then one sample per bit period.
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    w_start_ok  = 1'b0;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (prev_q && !w_rx) begin
          rx_state_d = R_START;
          cnt_d      = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (w_rx) begin
            rx_state_d = R_IDLE;
          end else begin
            rx_state_d = R_DATA;
            bit_d      = 3'd0;
            w_start_ok = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {w_rx, shift_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = R_STOP;
          else               bit_d      = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          cnt_d       = '0;
          rx_state_d  = R_IDLE;
          w_byte_done = w_rx;
          w_frame_err = !w_rx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    word_d      = word_q;
    bidx_d      = bidx_q;
    cnt_lo_d    = cnt_lo_q;
    n_d         = n_q;
    busy_d      = busy_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (w_start_ok) busy_d = 1'b1;
    if (mem_we_q)   mem_addr_d = mem_addr_q + 1'b1;
    case (state_q)
      S_CNT_LO: begin
        if (w_frame_err) state_d = S_ERR;
        else if (w_byte_done) begin
          cnt_lo_d = shift_q;
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (w_frame_err) state_d = S_ERR;
        else if (w_byte_done) begin
          n_d = w_n;
          if (32'(w_n) > 32'(MEM_WORDS)) state_d = S_ERR;
          else if (w_n == 16'd0)         state_d = S_AFTER_DATA;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_frame_err) state_d = S_ERR;
        else if (w_byte_done) begin
          if (bidx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {shift_q, word_q};
          end else begin
            word_d = {shift_q, word_q[23:8]};
          end
          bidx_d = bidx_q + 2'd1;
        end else if (mem_we_q && (w_next_idx == {1'b0, n_q})) begin
          state_d = S_AFTER_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_frame_err) state_d = S_ERR;
        else if (w_byte_done) state_d = (shift_q == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
`ifdef LOADER_CHECKSUM_EN
    if (w_byte_done && (state_q == S_CNT_LO || state_q == S_CNT_HI || state_q == S_DATA))
      csum_d = csum_q ^ shift_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      rx_state_q  <= R_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      state_q     <= S_CNT_LO;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      word_q      <= 24'd0;
      bidx_q      <= 2'd0;
      cnt_lo_q    <= 8'd0;
      n_q         <= 16'd0;
      busy_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      sync_q      <= {sync_q[0], ser_rx};
      prev_q      <= w_rx;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      cnt_lo_q    <= cnt_lo_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Status decodes straight from the state so busy falls exactly as done/err rise.
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign busy      = busy_q && !done && !err;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_mem_loader : directed vector bench for uart_mem_loader (CLKS_PER_BIT=4).
// Rev 1.0
// ============================================================================

module tb_uart_mem_loader;

  localparam int CPB = 4;
  localparam int AW  = 12;

  logic          clk;
  logic          rst_n;
  logic          ser_rx;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(2056), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .ser_rx   (ser_rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Write monitor: only this block writes these variables.
  int            wr_n     = 0;
  logic [AW-1:0] wr_addr [0:63];
  logic [31:0]   wr_data [0:63];
  int            wr_cyc  [0:63];
  int            we_long  = 0;
  logic          we_prev  = 1'b0;
  logic          done_prev = 1'b0;
  logic          err_prev  = 1'b0;
  int            done_cyc = -1;
  int            err_cyc  = -1;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
      if (we_prev) we_long = we_long + 1;
    end
    if (done && !done_prev) done_cyc = cyc;
    if (err && !err_prev)   err_cyc  = cyc;
    we_prev   = mem_we;
    done_prev = done;
    err_prev  = err;
  end

  typedef struct {
    int          nb;
    logic [95:0] b;
    int          bad_i;
    bit          add_cs;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
    logic [31:0] w0;
    logic [31:0] w1;
    int          ev;
  } vec_t;

  vec_t vecs [0:8];
  int   nvec;
  int   start_cyc [0:15];

  function automatic vec_t mk(input int nb, input logic [95:0] b, input int bad_i,
                              input bit add_cs, input bit d, input bit e, input int nw,
                              input logic [31:0] w0, input logic [31:0] w1, input int ev);
    vec_t v;
    v.nb = nb; v.b = b; v.bad_i = bad_i; v.add_cs = add_cs;
    v.exp_done = d; v.exp_err = e; v.exp_wr = nw; v.w0 = w0; v.w1 = w1; v.ev = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, output int st);
    @(posedge clk); #1 ser_rx = 1'b0;
    st = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 ser_rx = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 ser_rx = stop_ok;
    repeat (CPB) @(posedge clk);
    #1 ser_rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_stream(input logic [95:0] b, input int nb, input int bad_i, input bit add_cs);
    logic [7:0] cs;
    logic [7:0] x;
    int st;
    cs = 8'h00;
    for (int i = 0; i < nb; i++) begin
      x  = b[8*i +: 8];
      cs = cs ^ x;
      send_byte(x, i != bad_i, st);
      start_cyc[i] = st;
    end
`ifdef LOADER_CHECKSUM_EN
    if (add_cs) begin
      send_byte(cs, 1'b1, st);
      start_cyc[nb] = st;
    end
`endif
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check({tag, " rst mem_we"},    mem_we,    32'd0);
    check({tag, " rst mem_addr"},  mem_addr,  32'd0);
    check({tag, " rst mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " rst busy"},      busy,      32'd0);
    check({tag, " rst done"},      done,      32'd0);
    check({tag, " rst err"},       err,       32'd0);
    ser_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int base;
    int ev;
    int lat;
    int st;
    vec_t v;

    ser_rx = 1'b1;
    rst_n  = 1'b0;

    vecs[0] = mk(10, 96'h0000DEADBEEF123456780002, -1, 1, 1, 0, 2, 32'h12345678, 32'hDEADBEEF, 9);
    vecs[1] = mk(6,  96'h123456780002,              2, 1, 0, 1, 0, 32'h0, 32'h0, 2);
    vecs[2] = mk(2,  96'h0809,                     -1, 1, 0, 1, 0, 32'h0, 32'h0, 1);
    vecs[3] = mk(2,  96'h0000,                     -1, 1, 1, 0, 0, 32'h0, 32'h0, 1);
    vecs[4] = mk(6,  96'h800000000001,             -1, 1, 1, 0, 1, 32'h80000000, 32'h0, 5);
    vecs[5] = mk(2,  96'h0001,                      0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
    vecs[6] = mk(10, 96'h0000DEADBEEF123456780002,  9, 1, 0, 1, 1, 32'h12345678, 32'h0, 9);
    nvec = 7;
`ifdef LOADER_CHECKSUM_EN
    vecs[7] = mk(7, 96'h05040302010001, -1, 0, 1, 0, 1, 32'h04030201, 32'h0, 6);
    vecs[8] = mk(7, 96'h06040302010001, -1, 0, 0, 1, 1, 32'h04030201, 32'h0, 6);
    nvec = 9;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("por mem_we",   mem_we,   32'd0);
    check("por mem_addr", mem_addr, 32'd0);
    check("por busy",     busy,     32'd0);
    check("por done",     done,     32'd0);
    check("por err",      err,      32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < nvec; k++) begin
      v = vecs[k];
      do_reset($sformatf("v%0d", k));
      base = wr_n;
      send_stream(v.b, v.nb, v.bad_i, v.add_cs);
      repeat (2 * CPB) @(posedge clk);
      #1;
      check($sformatf("v%0d done", k),    done,         32'(v.exp_done));
      check($sformatf("v%0d err", k),     err,          32'(v.exp_err));
      check($sformatf("v%0d busy", k),    busy,         32'd0);
      check($sformatf("v%0d nwrites", k), wr_n - base,  v.exp_wr);
      check($sformatf("v%0d we_long", k), we_long,      32'd0);
      for (int w = 0; w < v.exp_wr && w < 2; w++) begin
        check($sformatf("v%0d addr%0d", k, w), wr_addr[base + w], w);
        check($sformatf("v%0d data%0d", k, w), wr_data[base + w], (w == 0) ? v.w0 : v.w1);
        check($sformatf("v%0d we_time%0d", k, w), wr_cyc[base + w], start_cyc[4*w + 5] + 41);
      end
      ev  = v.ev;
      lat = 41;
`ifdef LOADER_CHECKSUM_EN
      if (v.add_cs && v.exp_done) ev = v.nb;
`else
      if (v.exp_done && v.exp_wr > 0) lat = 42;
`endif
      if (v.exp_done) check($sformatf("v%0d done_time", k), done_cyc, start_cyc[ev] + lat);
      else            check($sformatf("v%0d err_time", k),  err_cyc,  start_cyc[ev] + 41);
    end

    // Short low glitch must be rejected; a full stream then loads normally.
    do_reset("glitch");
    base = wr_n;
    @(posedge clk); #1 ser_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 ser_rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch busy", busy, 32'd0);
    check("glitch err",  err,  32'd0);
    send_stream(96'h0000DEADBEEF123456780002, 10, -1, 1);
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("glitch done",    done,        32'd1);
    check("glitch nwrites", wr_n - base, 32'd2);
    check("glitch data0",   wr_data[base],     32'h12345678);
    check("glitch data1",   wr_data[base + 1], 32'hDEADBEEF);
    check("glitch addr_end", mem_addr,   32'd2);

    // Count exactly at capacity is accepted; busy holds while data is expected.
    do_reset("cap");
    send_byte(8'h08, 1'b1, st);
    #1 check("cap busy lo", busy, 32'd1);
    send_byte(8'h08, 1'b1, st);
    #1;
    check("cap busy hi", busy, 32'd1);
    check("cap err",     err,  32'd0);
    check("cap done",    done, 32'd0);

    // Terminal DONE ignores later traffic.
    do_reset("term");
    base = wr_n;
    send_stream(96'h0000, 2, -1, 1);
    send_stream(96'h04030201, 4, -1, 0);
    #1;
    check("term nwrites", wr_n - base, 32'd0);
    check("term done",    done,        32'd1);
    check("term err",     err,         32'd0);

    // Reset in the middle of a word and a byte discards all partial state.
    do_reset("mid");
    base = wr_n;
    send_stream(96'h55443322110002, 7, -1, 0);
    check("mid data0", wr_data[base], 32'h44332211);
    check("mid nwr0",  wr_n - base,   32'd1);
    @(posedge clk); #1 ser_rx = 1'b0;
    repeat (6) @(posedge clk);
    do_reset("mid2");
    base = wr_n;
    send_stream(96'hDDCCBBAA0001, 6, -1, 1);
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("mid nwrites", wr_n - base,   32'd1);
    check("mid addr",    wr_addr[base], 32'd0);
    check("mid data",    wr_data[base], 32'hDDCCBBAA);
    check("mid done",    done,          32'd1);
    check("mid err",     err,           32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
